// File: rtl/sdft_bin_update_pkg.sv
// Shared definitions for the sliding-DFT bin updater: controller states and
// the width / rounding helpers used by the datapath and twiddle table.
package sdft_bin_update_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam real TWO_PI = 6.283185307179586;

    // Half an LSB of the Q1.(tw_width-1) product, for round-half-up.
    function automatic int round_const(input int tw_width);
        return 1 << (tw_width - 2);
    endfunction

    // Complex product of an (acc+1)-bit operand and a tw-bit twiddle, plus
    // headroom for the cross-term sum and the rounding addend.
    function automatic int prod_width(input int acc_width, input int tw_width);
        return acc_width + tw_width + 3;
    endfunction

endpackage

// File: rtl/sdft_twiddle_rom.sv
// Synchronous-read cos/sin table for W^k = exp(+j*2*pi*k/N), Q1.(TW_WIDTH-1),
// built at elaboration; +1.0 saturates to the largest positive code.
module sdft_twiddle_rom
    import sdft_bin_update_pkg::*;
#(
    parameter int FFT_SIZE = 256,
    parameter int TW_WIDTH = 16
) (
    input  logic                          clk,
    input  logic [$clog2(FFT_SIZE)-1:0]   addr,
    output logic signed [TW_WIDTH-1:0]    cos_q,
    output logic signed [TW_WIDTH-1:0]    sin_q
);

    localparam real SCALE  = 2.0 ** (TW_WIDTH - 1);
    localparam int  TW_MAX = (1 << (TW_WIDTH - 1)) - 1;
    localparam int  TW_MIN = -TW_MAX - 1;

    logic signed [TW_WIDTH-1:0] cos_tab [FFT_SIZE];
    logic signed [TW_WIDTH-1:0] sin_tab [FFT_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < FFT_SIZE; gi++) begin : g_tab
            localparam real ANG   = TWO_PI * gi / FFT_SIZE;
            localparam real C_S   = $cos(ANG) * SCALE;
            localparam real S_S   = $sin(ANG) * SCALE;
            localparam int  C_Q   = (C_S >= 0.0) ? $rtoi(C_S + 0.5) : -$rtoi(0.5 - C_S);
            localparam int  S_Q   = (S_S >= 0.0) ? $rtoi(S_S + 0.5) : -$rtoi(0.5 - S_S);
            localparam int  C_T   = (C_Q > TW_MAX) ? TW_MAX : ((C_Q < TW_MIN) ? TW_MIN : C_Q);
            localparam int  S_T   = (S_Q > TW_MAX) ? TW_MAX : ((S_Q < TW_MIN) ? TW_MIN : S_Q);
            assign cos_tab[gi] = TW_WIDTH'(C_T);
            assign sin_tab[gi] = TW_WIDTH'(S_T);
        end
    endgenerate

    always_ff @(posedge clk) begin
        cos_q <= cos_tab[addr];
        sin_q <= sin_tab[addr];
    end

endmodule

// File: rtl/sdft_bin_update.sv
// Sliding-DFT bin updater: X_k <= (X_k - sample_diff) * W^k, three-stage pipeline.
// Optional SDFT_SATURATE_EN clamps results to the ACC_WIDTH range instead of wrapping.
module sdft_bin_update
    import sdft_bin_update_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int FFT_SIZE   = 256,
    parameter int ACC_WIDTH  = 24,
    parameter int TW_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [$clog2(FFT_SIZE)-1:0]   in_idx,
    input  logic signed [WORD_WIDTH-1:0]  sample_diff,
    output logic                          ready,
    output logic                          out_valid,
    output logic [$clog2(FFT_SIZE)-1:0]   out_idx,
    output logic signed [ACC_WIDTH-1:0]   out_re,
    output logic signed [ACC_WIDTH-1:0]   out_im,
    output logic                          frame_done,
    output logic                          drop_err
);

    localparam int IDX_W  = $clog2(FFT_SIZE);
    localparam int PROD_W = prod_width(ACC_WIDTH, TW_WIDTH);
    localparam logic signed [PROD_W-1:0] RND      = PROD_W'(round_const(TW_WIDTH));
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(FFT_SIZE - 1);
`ifdef SDFT_SATURATE_EN
    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W - ACC_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}};
`endif

    // Drops the Q-format fraction of a rounded product and fits it to ACC_WIDTH.
    function automatic logic signed [ACC_WIDTH-1:0] narrow(input logic signed [PROD_W-1:0] sum);
        logic signed [PROD_W-1:0] shifted;
        shifted = sum >>> (TW_WIDTH - 1);
`ifdef SDFT_SATURATE_EN
        if (shifted > SAT_MAX)
            return SAT_MAX[ACC_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            return SAT_MIN[ACC_WIDTH-1:0];
        return shifted[ACC_WIDTH-1:0];
`else
        return ACC_WIDTH'(shifted);
`endif
    endfunction

    state_t                       state_reg;
    logic [IDX_W-1:0]             clr_addr_reg;
    logic                         drop_err_reg;
    logic                         accept;

    logic                         s1_valid_reg;
    logic [IDX_W-1:0]             s1_idx_reg;
    logic signed [WORD_WIDTH-1:0] s1_diff_reg;
    logic signed [ACC_WIDTH-1:0]  rd_re_reg, rd_im_reg;
    logic signed [TW_WIDTH-1:0]   tw_cos, tw_sin;

    logic signed [ACC_WIDTH:0]    sub_re, sub_im;
    logic signed [PROD_W-1:0]     prod_re_next, prod_im_next;

    logic                         s2_valid_reg;
    logic [IDX_W-1:0]             s2_idx_reg;
    logic signed [PROD_W-1:0]     s2_re_reg, s2_im_reg;
    logic signed [ACC_WIDTH-1:0]  res_re, res_im;

    logic                         out_valid_reg, frame_done_reg;
    logic [IDX_W-1:0]             out_idx_reg;
    logic signed [ACC_WIDTH-1:0]  out_re_reg, out_im_reg;

    logic signed [ACC_WIDTH-1:0]  ram_re [FFT_SIZE];
    logic signed [ACC_WIDTH-1:0]  ram_im [FFT_SIZE];

    assign ready  = (state_reg == ST_RUN);
    assign accept = in_valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
            drop_err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_CLEAR) begin
                clr_addr_reg <= clr_addr_reg + IDX_W'(1);
                if (clr_addr_reg == LAST_IDX)
                    state_reg <= ST_RUN;
            end
            if (in_valid && !ready)
                drop_err_reg <= 1'b1;
        end
    end

    sdft_twiddle_rom #(
        .FFT_SIZE (FFT_SIZE),
        .TW_WIDTH (TW_WIDTH)
    ) u_twiddle (
        .clk   (clk),
        .addr  (in_idx),
        .cos_q (tw_cos),
        .sin_q (tw_sin)
    );

    // Bin RAM: read port follows the request index, the single write port is
    // shared between zeroing during CLEAR and pipeline write-back during RUN.
    always_ff @(posedge clk) begin
        rd_re_reg <= ram_re[in_idx];
        rd_im_reg <= ram_im[in_idx];
        if (!reset) begin
            if (state_reg == ST_CLEAR) begin
                ram_re[clr_addr_reg] <= '0;
                ram_im[clr_addr_reg] <= '0;
            end else if (s2_valid_reg) begin
                ram_re[s2_idx_reg] <= res_re;
                ram_im[s2_idx_reg] <= res_im;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            s2_valid_reg <= s1_valid_reg;
        end
        s1_idx_reg  <= in_idx;
        s1_diff_reg <= sample_diff;
        s2_idx_reg  <= s1_idx_reg;
        s2_re_reg   <= prod_re_next;
        s2_im_reg   <= prod_im_next;
    end

    always_comb begin
        sub_re       = (ACC_WIDTH + 1)'(rd_re_reg) - (ACC_WIDTH + 1)'(s1_diff_reg);
        sub_im       = (ACC_WIDTH + 1)'(rd_im_reg);
        prod_re_next = PROD_W'(sub_re) * PROD_W'(tw_cos) - PROD_W'(sub_im) * PROD_W'(tw_sin);
        prod_im_next = PROD_W'(sub_re) * PROD_W'(tw_sin) + PROD_W'(sub_im) * PROD_W'(tw_cos);
        res_re       = narrow(s2_re_reg + RND);
        res_im       = narrow(s2_im_reg + RND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            out_idx_reg    <= '0;
            out_re_reg     <= '0;
            out_im_reg     <= '0;
        end else begin
            out_valid_reg  <= s2_valid_reg;
            frame_done_reg <= s2_valid_reg && (s2_idx_reg == LAST_IDX);
            if (s2_valid_reg) begin
                out_idx_reg <= s2_idx_reg;
                out_re_reg  <= res_re;
                out_im_reg  <= res_im;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign frame_done = frame_done_reg;
    assign out_idx    = out_idx_reg;
    assign out_re     = out_re_reg;
    assign out_im     = out_im_reg;
    assign drop_err   = drop_err_reg;

endmodule

// File: tb/tb_sdft_bin_update.sv
// Randomised self-checking bench for sdft_bin_update (N=8, ACC 17) against a
// complex-arithmetic reference model; honours SDFT_SATURATE_EN when defined.
module tb_sdft_bin_update;

    localparam int N  = 8;
    localparam int WW = 16;
    localparam int AW = 17;
    localparam int TW = 16;
    localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (AW - 1));
    localparam longint RND  = 64'sd1 <<< (TW - 2);

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid = 1'b0;
    logic [2:0]            in_idx = '0;
    logic signed [WW-1:0]  sample_diff = '0;
    logic                  ready, out_valid, frame_done, drop_err;
    logic [2:0]            out_idx;
    logic signed [AW-1:0]  out_re, out_im;

    always #5 clk = ~clk;

    sdft_bin_update #(
        .WORD_WIDTH (WW),
        .FFT_SIZE   (N),
        .ACC_WIDTH  (AW),
        .TW_WIDTH   (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_idx      (in_idx),
        .sample_diff (sample_diff),
        .ready       (ready),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_re      (out_re),
        .out_im      (out_im),
        .frame_done  (frame_done),
        .drop_err    (drop_err)
    );

    typedef struct {
        int     due;
        int     idx;
        longint re;
        longint im;
    } exp_t;

    exp_t   pend_q[$];
    longint bin_re[N], bin_im[N], tw_c[N], tw_s[N];
    int     cycle = 0;
    int     clear_left = N;
    bit     e_valid = 0, e_fd = 0, e_drop = 0;
    int     e_idx = 0;
    longint e_re = 0, e_im = 0;
    int     n_checks = 0, n_fail = 0;
    logic [40:0] dut_vec;

    assign dut_vec = {out_valid, out_idx, out_re, out_im, frame_done, ready, drop_err};

    function automatic logic [40:0] expected_vec();
        return {e_valid, 3'(e_idx), AW'(e_re), AW'(e_im), e_fd, (clear_left == 0), e_drop};
    endfunction

    function automatic longint quant(real x);
        real    s;
        longint q;
        s = x * 32768.0;
        q = (s >= 0.0) ? longint'($rtoi(s + 0.5)) : -longint'($rtoi(0.5 - s));
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    function automatic longint fit(longint v);
`ifdef SDFT_SATURATE_EN
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
`else
        longint m, r;
        m = 64'sd1 <<< AW;
        r = v % m;
        if (r < 0) r += m;
        if (r > MAXV) r -= m;
        return r;
`endif
    endfunction

    task automatic drive(input bit v, input int idx, input longint diff);
        in_valid    = v;
        in_idx      = 3'(idx);
        sample_diff = WW'(diff);
    endtask

    // One clock: apply the spec's update rule to the request being sampled,
    // advance, then derive what the outputs must show in the new cycle.
    task automatic tick();
        bit     rst, drop_now;
        exp_t   e;
        longint a, b;
        int     k;
        rst = reset;
        drop_now = 0;
        k = int'(in_idx);
        if (!rst && in_valid) begin
            if (clear_left == 0) begin
                a = bin_re[k] - longint'(sample_diff);
                b = bin_im[k];
                bin_re[k] = fit((a * tw_c[k] - b * tw_s[k] + RND) >>> (TW - 1));
                bin_im[k] = fit((a * tw_s[k] + b * tw_c[k] + RND) >>> (TW - 1));
                e.due = cycle + 3;
                e.idx = k;
                e.re  = bin_re[k];
                e.im  = bin_im[k];
                pend_q.push_back(e);
            end else begin
                drop_now = 1;
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (rst) begin
            clear_left = N;
            pend_q.delete();
            e_valid = 0; e_fd = 0; e_drop = 0; e_idx = 0; e_re = 0; e_im = 0;
            for (int i = 0; i < N; i++) begin
                bin_re[i] = 0;
                bin_im[i] = 0;
            end
        end else begin
            if (clear_left > 0) clear_left--;
            if (drop_now) e_drop = 1;
            e_valid = 0;
            e_fd    = 0;
            if (pend_q.size() > 0 && pend_q[0].due == cycle) begin
                e = pend_q.pop_front();
                e_valid = 1;
                e_fd    = (e.idx == N - 1);
                e_idx   = e.idx;
                e_re    = e.re;
                e_im    = e.im;
            end
        end
        if (out_valid === 1'b1)
            $display("cyc %0d out idx=%0d re=%0d im=%0d frame_done=%0b",
                     cycle, out_idx, out_re, out_im, frame_done);
    endtask

    task automatic test_reset();
        int rise;
        bit saw_valid;
        rise = -1;
        saw_valid = 0;
        reset = 1'b1;
        drive(0, 0, 0);
        repeat (3) begin
            tick();
            n_checks++;
            if (dut_vec !== expected_vec()) begin
                n_fail++;
                $display("FAIL reset_values cyc %0d: got %h required %h", cycle, dut_vec, expected_vec());
            end
        end
        reset = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            drive(n <= 8, $urandom_range(0, N - 1), longint'($urandom_range(0, 65535)) - 32768);
            tick();
            n_checks++;
            if (dut_vec !== expected_vec()) begin
                n_fail++;
                $display("FAIL clear_phase cyc %0d: got %h required %h", cycle, dut_vec, expected_vec());
            end
            if (out_valid === 1'b1) saw_valid = 1;
            if (ready === 1'b1 && rise < 0) rise = n;
        end
        drive(0, 0, 0);
        n_checks++;
        if (rise != 8) begin
            n_fail++;
            $display("FAIL ready_rise: got %0d cycles required 8", rise);
        end
        n_checks++;
        if (drop_err !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_err_sticky: got %b required 1", drop_err);
        end
        n_checks++;
        if (saw_valid) begin
            n_fail++;
            $display("FAIL no_out_in_clear: got out_valid 1 required 0");
        end
    endtask

    task automatic test_frames();
        longint got_re[$], got_im[$];
        int     lat;
        lat = -1;
        for (int j = 0; j < 2 * N + 4; j++) begin
            if (j < 2 * N) drive(1, j % N, -100);
            else drive(0, 0, 0);
            tick();
            n_checks++;
            if (dut_vec !== expected_vec()) begin
                n_fail++;
                $display("FAIL frames cyc %0d: got %h required %h", cycle, dut_vec, expected_vec());
            end
            if (out_valid === 1'b1) begin
                if (lat < 0) lat = j + 1;
                got_re.push_back(longint'(out_re));
                got_im.push_back(longint'(out_im));
            end
        end
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL first_latency: got %0d required 3", lat);
        end
        n_checks++;
        if (got_re.size() != 2 * N) begin
            n_fail++;
            $display("FAIL frame_outputs: got %0d required %0d", got_re.size(), 2 * N);
        end else begin
            n_checks++;
            if (got_re[0] != 100 || got_im[0] != 0) begin
                n_fail++;
                $display("FAIL f1_k0: got (%0d,%0d) required (100,0)", got_re[0], got_im[0]);
            end
            n_checks++;
            if (got_re[2] != 0 || got_im[2] != 100) begin
                n_fail++;
                $display("FAIL f1_k2: got (%0d,%0d) required (0,100)", got_re[2], got_im[2]);
            end
            n_checks++;
            if (got_re[4] != -100 || got_im[4] != 0) begin
                n_fail++;
                $display("FAIL f1_k4: got (%0d,%0d) required (-100,0)", got_re[4], got_im[4]);
            end
            n_checks++;
            if (got_re[8] != 200 || got_im[8] != 0) begin
                n_fail++;
                $display("FAIL f2_k0: got (%0d,%0d) required (200,0)", got_re[8], got_im[8]);
            end
            n_checks++;
            if (got_re[10] != -100 || got_im[10] != 100) begin
                n_fail++;
                $display("FAIL f2_k2: got (%0d,%0d) required (-100,100)", got_re[10], got_im[10]);
            end
        end
    endtask

    task automatic test_random();
        int     ord[N];
        int     j, t;
        longint diff;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) ord[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            diff = (f < 3) ? longint'($urandom_range(0, 2000)) - 1000
                           : longint'($urandom_range(0, 65535)) - 32768;
            for (int i = 0; i < N + 3; i++) begin
                if (i < N && $urandom_range(0, 3) == 0) begin
                    drive(0, 0, diff);
                    tick();
                    n_checks++;
                    if (dut_vec !== expected_vec()) begin
                        n_fail++;
                        $display("FAIL random_bubble cyc %0d: got %h required %h", cycle, dut_vec, expected_vec());
                    end
                end
                if (i < N) drive(1, ord[i], diff);
                else drive(0, 0, diff);
                tick();
                n_checks++;
                if (dut_vec !== expected_vec()) begin
                    n_fail++;
                    $display("FAIL random cyc %0d: got %h required %h", cycle, dut_vec, expected_vec());
                end
            end
        end
    endtask

    task automatic test_saturation();
        longint k0[$];
        drive(0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 20 && ready !== 1'b1; n++) begin
            tick();
            n_checks++;
            if (dut_vec !== expected_vec()) begin
                n_fail++;
                $display("FAIL sat_clear cyc %0d: got %h required %h", cycle, dut_vec, expected_vec());
            end
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_ready_timeout: got %b required 1", ready);
        end
        for (int j = 0; j < 3 * N + 4; j++) begin
            if (j < 3 * N) drive(1, j % N, -32768);
            else drive(0, 0, 0);
            tick();
            n_checks++;
            if (dut_vec !== expected_vec()) begin
                n_fail++;
                $display("FAIL saturation cyc %0d: got %h required %h", cycle, dut_vec, expected_vec());
            end
            if (out_valid === 1'b1 && out_idx == 3'd0) k0.push_back(longint'(out_re));
        end
        n_checks++;
        if (k0.size() != 3) begin
            n_fail++;
            $display("FAIL sat_k0_count: got %0d required 3", k0.size());
        end else begin
            n_checks++;
            if (k0[0] != 32767) begin
                n_fail++;
                $display("FAIL sat_f1_k0: got %0d required 32767", k0[0]);
            end
            n_checks++;
            if (k0[1] != 65533) begin
                n_fail++;
                $display("FAIL sat_f2_k0: got %0d required 65533", k0[1]);
            end
`ifdef SDFT_SATURATE_EN
            n_checks++;
            if (k0[2] != 65535) begin
                n_fail++;
                $display("FAIL sat_f3_clamp: got %0d required 65535", k0[2]);
            end
`else
            n_checks++;
            if (k0[2] >= 0) begin
                n_fail++;
                $display("FAIL sat_f3_wrap: got %0d required negative", k0[2]);
            end
`endif
        end
    endtask

    task automatic test_reset_midframe();
        int     rise;
        longint k0_re, k0_im;
        bit     k0_seen;
        rise = -1;
        k0_seen = 0;
        k0_re = 0;
        k0_im = 0;
        for (int j = 0; j < 4; j++) begin
            drive(1, j, -50);
            tick();
            n_checks++;
            if (dut_vec !== expected_vec()) begin
                n_fail++;
                $display("FAIL midframe_pre cyc %0d: got %h required %h", cycle, dut_vec, expected_vec());
            end
        end
        drive(1, 4, -50);
        reset = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_flush: got out_valid %b required 0", out_valid);
        end
        reset = 1'b0;
        drive(0, 0, 0);
        for (int n = 1; n <= 20 && rise < 0; n++) begin
            tick();
            n_checks++;
            if (dut_vec !== expected_vec()) begin
                n_fail++;
                $display("FAIL midframe_clear cyc %0d: got %h required %h", cycle, dut_vec, expected_vec());
            end
            if (ready === 1'b1) rise = n;
        end
        n_checks++;
        if (rise != 8) begin
            n_fail++;
            $display("FAIL midframe_ready_rise: got %0d cycles required 8", rise);
        end
        for (int j = 0; j < N + 4; j++) begin
            if (j < N) drive(1, j, -1);
            else drive(0, 0, 0);
            tick();
            n_checks++;
            if (dut_vec !== expected_vec()) begin
                n_fail++;
                $display("FAIL midframe_post cyc %0d: got %h required %h", cycle, dut_vec, expected_vec());
            end
            if (out_valid === 1'b1 && out_idx == 3'd0 && !k0_seen) begin
                k0_seen = 1;
                k0_re = longint'(out_re);
                k0_im = longint'(out_im);
            end
        end
        n_checks++;
        if (!k0_seen || k0_re != 1 || k0_im != 0) begin
            n_fail++;
            $display("FAIL midframe_k0: got seen=%0b (%0d,%0d) required (1,0)", k0_seen, k0_re, k0_im);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            tw_c[k]   = quant($cos(2.0 * 3.141592653589793 * k / N));
            tw_s[k]   = quant($sin(2.0 * 3.141592653589793 * k / N));
            bin_re[k] = 0;
            bin_im[k] = 0;
        end
        test_reset();
        test_frames();
        test_random();
        test_saturation();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
